// File: rtl/codec_i2c_pkg.sv
// Shared types and constants for the codec I2C register-write responder.
// The read-back path (RD_BYTE/RD_ACK states) exists only when I2C_READ_EN is defined.
package codec_i2c_pkg;

  localparam int         CODEC_REG_AW      = 7;
  localparam int         CODEC_REG_DW      = 9;
  localparam logic [6:0] CODEC_DEV_ADDR    = 7'h1A;
  localparam logic [8:0] CODEC_REG_RST_VAL = 9'h000;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_BYTE0,
    ST_ACK0,
    ST_BYTE1,
    ST_ACK1,
    ST_IGNORE
`ifdef I2C_READ_EN
    , ST_RD_BYTE
    , ST_RD_ACK
`endif
  } i2c_resp_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser plus stability filter for one open-drain line;
// emits the accepted level and single-cycle rise/fall flags.
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int            CW   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level, r_rise, r_fall;

  // Idle bus is high, so reset to 1 to avoid a false edge out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_level <= 1'b1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_pin};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_cnt   <= '0;
        r_level <= r_sync[1];
        r_rise  <= r_sync[1];
        r_fall  <= ~r_sync[1];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/codec_i2c_responder.sv
// I2C target for SSM2603-style 2-byte register writes with a shadow register file.
// Define I2C_READ_EN to also answer addr+R with the register at the last latched RA.
module codec_i2c_responder
  import codec_i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = CODEC_DEV_ADDR,
  parameter int         NUM_REGS   = 19,
  parameter logic [6:0] RESET_REG  = 7'h0F,
  parameter int         FILTER_LEN = 3,
  parameter int         SDA_HOLD   = 4
) (
  input  logic                    s00_axi_aclk,
  input  logic                    s00_axi_aresetn,
  input  logic                    i2c_scl_i,
  input  logic                    i2c_sda_i,
  output logic                    i2c_sda_t,
  output logic                    reg_wr_valid,
  output logic [CODEC_REG_AW-1:0] reg_wr_addr,
  output logic [CODEC_REG_DW-1:0] reg_wr_data,
  input  logic [CODEC_REG_AW-1:0] cfg_rd_addr,
  output logic [CODEC_REG_DW-1:0] cfg_rd_data,
  output logic                    bus_busy,
  output logic [7:0]              nack_count
);

  localparam int            HW      = $clog2(SDA_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LD = HW'(SDA_HOLD);
  localparam logic [6:0]    REG_LIM = 7'(NUM_REGS);

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .i_clk(s00_axi_aclk), .i_rst_n(s00_axi_aresetn), .i_pin(i2c_scl_i),
    .o_level(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .i_clk(s00_axi_aclk), .i_rst_n(s00_axi_aresetn), .i_pin(i2c_sda_i),
    .o_level(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
  );

  assign w_start = w_sda_fall & w_scl;
  assign w_stop  = w_sda_rise & w_scl;

  i2c_resp_state_t r_state;
  logic [7:0]      r_shift;
  logic [3:0]      r_bitcnt;
  logic [6:0]      r_ra;
  logic            r_d8;
  logic [7:0]      r_dlo;
  logic            r_sda_t, r_sda_pend;
  logic [HW-1:0]   r_hold_cnt;
  logic            r_wr_valid;
  logic [6:0]      r_wr_addr;
  logic [8:0]      r_wr_data;
  logic            r_busy;
  logic [7:0]      r_nack_cnt;
  logic [8:0]      r_rf [NUM_REGS];
  logic [8:0]      w_cfg_data;

`ifdef I2C_READ_EN
  logic       r_rd, r_rd_lo, r_mack;
  logic [7:0] r_tx;
  logic [8:0] w_ra_data;

  always_comb begin
    w_ra_data = CODEC_REG_RST_VAL;
    for (int i = 0; i < NUM_REGS; i++)
      if (r_ra == 7'(i)) w_ra_data = r_rf[i];
  end
`endif

  always_comb begin
    w_cfg_data = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (cfg_rd_addr == 7'(i)) w_cfg_data = r_rf[i];
  end

  // Every SDA change is deferred SDA_HOLD clocks past the SCL fall via r_hold_cnt.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_ra       <= '0;
      r_d8       <= 1'b0;
      r_dlo      <= '0;
      r_sda_t    <= 1'b1;
      r_sda_pend <= 1'b1;
      r_hold_cnt <= '0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_busy     <= 1'b0;
      r_nack_cnt <= '0;
`ifdef I2C_READ_EN
      r_rd       <= 1'b0;
      r_rd_lo    <= 1'b0;
      r_mack     <= 1'b0;
      r_tx       <= '0;
`endif
    end else begin
      r_wr_valid <= 1'b0;
      if (r_hold_cnt != '0) begin
        r_hold_cnt <= r_hold_cnt - 1'b1;
        if (r_hold_cnt == HW'(1)) r_sda_t <= r_sda_pend;
      end
      if (w_start) begin
        r_state    <= ST_ADDR;
        r_bitcnt   <= '0;
        r_sda_t    <= 1'b1;
        r_hold_cnt <= '0;
        r_busy     <= 1'b1;
`ifdef I2C_READ_EN
        r_rd       <= 1'b0;
`endif
      end else if (w_stop) begin
        r_state    <= ST_IDLE;
        r_sda_t    <= 1'b1;
        r_hold_cnt <= '0;
        r_busy     <= 1'b0;
      end else if (w_scl_rise) begin
        case (r_state)
          ST_ADDR, ST_BYTE0, ST_BYTE1: begin
            r_shift  <= {r_shift[6:0], w_sda};
            r_bitcnt <= r_bitcnt + 4'd1;
          end
`ifdef I2C_READ_EN
          ST_RD_ACK: r_mack <= ~w_sda;
`endif
          default: ;
        endcase
      end else if (w_scl_fall) begin
        case (r_state)
          ST_ADDR: if (r_bitcnt == 4'd8) begin
            r_bitcnt <= '0;
            if (r_shift[7:1] == DEV_ADDR && !r_shift[0]) begin
              r_state    <= ST_ADDR_ACK;
              r_sda_pend <= 1'b0;
              r_hold_cnt <= HOLD_LD;
            end
`ifdef I2C_READ_EN
            else if (r_shift[7:1] == DEV_ADDR) begin
              r_state    <= ST_ADDR_ACK;
              r_rd       <= 1'b1;
              r_sda_pend <= 1'b0;
              r_hold_cnt <= HOLD_LD;
            end
`endif
            else begin
              r_state    <= ST_IGNORE;
              r_nack_cnt <= sat_inc8(r_nack_cnt);
            end
          end
          ST_ADDR_ACK:
`ifdef I2C_READ_EN
            if (r_rd) begin
              r_state    <= ST_RD_BYTE;
              r_tx       <= {7'b0, w_ra_data[8]};
              r_rd_lo    <= 1'b1;
              r_sda_pend <= 1'b0;
              r_hold_cnt <= HOLD_LD;
            end else
`endif
            begin
              r_state    <= ST_BYTE0;
              r_sda_pend <= 1'b1;
              r_hold_cnt <= HOLD_LD;
            end
          ST_BYTE0: if (r_bitcnt == 4'd8) begin
            r_bitcnt <= '0;
            r_ra     <= r_shift[7:1];
            r_d8     <= r_shift[0];
            if (r_shift[7:1] < REG_LIM) begin
              r_state    <= ST_ACK0;
              r_sda_pend <= 1'b0;
              r_hold_cnt <= HOLD_LD;
            end else begin
              r_state    <= ST_IGNORE;
              r_nack_cnt <= sat_inc8(r_nack_cnt);
            end
          end
          ST_ACK0: begin
            r_state    <= ST_BYTE1;
            r_sda_pend <= 1'b1;
            r_hold_cnt <= HOLD_LD;
          end
          ST_BYTE1: if (r_bitcnt == 4'd8) begin
            r_bitcnt   <= '0;
            r_dlo      <= r_shift;
            r_state    <= ST_ACK1;
            r_sda_pend <= 1'b0;
            r_hold_cnt <= HOLD_LD;
          end
          ST_ACK1: begin
            r_state    <= ST_IGNORE;
            r_sda_pend <= 1'b1;
            r_hold_cnt <= HOLD_LD;
            r_wr_valid <= 1'b1;
            r_wr_addr  <= r_ra;
            r_wr_data  <= {r_d8, r_dlo};
          end
`ifdef I2C_READ_EN
          ST_RD_BYTE: if (r_bitcnt == 4'd7) begin
            r_bitcnt   <= '0;
            r_state    <= ST_RD_ACK;
            r_sda_pend <= 1'b1;
            r_hold_cnt <= HOLD_LD;
          end else begin
            r_bitcnt   <= r_bitcnt + 4'd1;
            r_tx       <= {r_tx[6:0], 1'b0};
            r_sda_pend <= r_tx[6];
            r_hold_cnt <= HOLD_LD;
          end
          // Low byte after the high byte, then 0xFF for any further master ACK.
          ST_RD_ACK: if (r_mack) begin
            r_state    <= ST_RD_BYTE;
            r_tx       <= r_rd_lo ? w_ra_data[7:0] : 8'hFF;
            r_sda_pend <= r_rd_lo ? w_ra_data[7] : 1'b1;
            r_rd_lo    <= 1'b0;
            r_hold_cnt <= HOLD_LD;
          end else begin
            r_state <= ST_IGNORE;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // Register file follows the committed write one clock after the pulse.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) r_rf[i] <= CODEC_REG_RST_VAL;
    end else if (r_wr_valid) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (r_wr_addr == RESET_REG)     r_rf[i] <= CODEC_REG_RST_VAL;
        else if (r_wr_addr == 7'(i))    r_rf[i] <= r_wr_data;
      end
    end
  end

  assign i2c_sda_t    = r_sda_t;
  assign reg_wr_valid = r_wr_valid;
  assign reg_wr_addr  = r_wr_addr;
  assign reg_wr_data  = r_wr_data;
  assign cfg_rd_data  = w_cfg_data;
  assign bus_busy     = r_busy;
  assign nack_count   = r_nack_cnt;

endmodule

// File: tb/tb_codec_i2c_responder.sv
// Bit-banged I2C initiator driving the responder; frame-level reference model
// feeds a commit scoreboard checked by an independent monitor process.
module tb_codec_i2c_responder;

  localparam int HP   = 20;
  localparam int Q    = 8;
  localparam int NREG = 19;
  localparam logic [7:0] WR_ADDR = 8'h34;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_line, sda_t;
  logic       wr_v, busy;
  logic [6:0] wr_a, rd_a;
  logic [8:0] wr_d, rd_d;
  logic [7:0] nackc;

  int checks = 0;
  int errors = 0;

  logic [8:0]  m_rf [NREG];
  int          m_nack = 0;
  logic [15:0] sb_q [$];

  assign sda_line = m_sda & sda_t;

  always #5 clk = ~clk;

  codec_i2c_responder dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .i2c_scl_i(m_scl), .i2c_sda_i(sda_line), .i2c_sda_t(sda_t),
    .reg_wr_valid(wr_v), .reg_wr_addr(wr_a), .reg_wr_data(wr_d),
    .cfg_rd_addr(rd_a), .cfg_rd_data(rd_d),
    .bus_busy(busy), .nack_count(nackc)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, act, exp);
    end
  endtask

  // Commit monitor: every reg_wr_valid cycle must match the oldest expected write.
  always @(negedge clk) begin
    if (wr_v) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected got %0h/%0h exp none", wr_a, wr_d);
      end else begin
        logic [15:0] e;
        e = sb_q.pop_front();
        chk("wr_commit", 32'({wr_a, wr_d}), 32'(e));
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_nack_inc();
    if (m_nack < 255) m_nack++;
  endtask

  task automatic m_commit(input logic [6:0] ra, input logic [8:0] d);
    if (ra == 7'h0F) for (int i = 0; i < NREG; i++) m_rf[i] = 9'h000;
    else m_rf[int'(ra)] = d;
  endtask

  task automatic put_bit(input bit b, input bit glitch = 1'b0);
    clks(Q);
    m_sda = b;
    if (glitch) begin
      clks(4); m_scl = 1'b1; clks(1); m_scl = 1'b0; clks(HP - 5);
    end else clks(HP);
    m_scl = 1'b1;
    clks(HP);
    m_scl = 1'b0;
  endtask

  task automatic get_bit(output bit b);
    clks(Q);
    m_sda = 1'b1;
    clks(HP);
    m_scl = 1'b1;
    clks(HP / 2);
    b = sda_line;
    clks(HP / 2);
    m_scl = 1'b0;
  endtask

  // exp_ack: 0 = line pulled low by the target, 1 = released.
  task automatic send_byte(input logic [7:0] v, input bit exp_ack, input string nm,
                           input bit glitch = 1'b0);
    bit a;
    for (int i = 7; i >= 0; i--) put_bit(v[i], glitch && i == 4);
    get_bit(a);
    chk(nm, 32'(a), 32'(exp_ack));
  endtask

  task automatic i2c_start();
    clks(Q); m_sda = 1'b1; clks(HP); m_scl = 1'b1; clks(HP); m_sda = 1'b0; clks(HP); m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    clks(Q); m_sda = 1'b0; clks(HP); m_scl = 1'b1; clks(HP); m_sda = 1'b1; clks(HP);
  endtask

  task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input int nb, input bit stop, input bit glitch = 1'b0);
    bit aok, rok;
    logic [6:0] ra;
    rok = 1'b0;
    i2c_start();
    chk("busy_start", 32'(busy), 1);
    aok = (b0 == WR_ADDR);
    if (!aok) m_nack_inc();
    send_byte(b0, !aok, "ack_addr");
    if (nb >= 2) begin
      ra  = b1[7:1];
      rok = aok && (int'(ra) < NREG);
      if (aok && !rok) m_nack_inc();
      send_byte(b1, !rok, "ack_ra", glitch);
    end
    if (nb >= 3) begin
      if (rok) begin
        sb_q.push_back({ra, b1[0], b2});
        m_commit(ra, {b1[0], b2});
      end
      send_byte(b2, !rok, "ack_data");
    end
    if (stop) begin
      i2c_stop();
      chk("busy_stop", 32'(busy), 0);
    end
  endtask

  task automatic check_regs();
    for (int i = 0; i < NREG; i++) begin
      rd_a = 7'(i);
      clks(1);
      chk($sformatf("cfg_rd[%0d]", i), 32'(rd_d), 32'(m_rf[i]));
    end
    rd_a = 7'h7F;
    clks(1);
    chk("cfg_rd_oor", 32'(rd_d), 0);
    chk("nack_count", 32'(nackc), 32'(m_nack));
  endtask

`ifdef I2C_READ_EN
  task automatic rd_byte(output logic [7:0] v);
    bit b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      v[i] = b;
    end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b0, b1, b2, bv;
    logic [6:0] ra;
    int nb;
    bit stp;
    for (int i = 0; i < NREG; i++) m_rf[i] = 9'h000;
    rd_a = 7'h00;
    clks(3);
    chk("rst_sda_t", 32'(sda_t), 1);
    chk("rst_wr_valid", 32'(wr_v), 0);
    chk("rst_wr_addr", 32'(wr_a), 0);
    chk("rst_wr_data", 32'(wr_d), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_nack", 32'(nackc), 0);
    rst_n = 1'b1;
    clks(10);
    check_regs();

    frame(WR_ADDR, 8'h0C, 8'h12, 3, 1);          // reg 6 = 0x012
    check_regs();
    frame(8'h36, 8'h0C, 8'h12, 3, 1);            // wrong device
    check_regs();
    frame(WR_ADDR, 8'hFE, 8'h55, 3, 1);          // RA 0x7F out of range
    check_regs();
    for (int i = 0; i < 5; i++) begin
      b2 = 8'($urandom);
      frame(WR_ADDR, {7'(i), 1'b1}, b2, 3, 1);
    end
    check_regs();
    frame(WR_ADDR, 8'h1E, 8'hAB, 3, 1);          // reset register
    check_regs();
    frame(WR_ADDR, 8'h04, 8'h00, 2, 0);          // aborted by repeated START
    frame(WR_ADDR, 8'h04, 8'h77, 3, 1);
    check_regs();
`ifdef I2C_READ_EN
    frame(WR_ADDR, 8'h09, 8'hA5, 3, 1);
    frame(WR_ADDR, 8'h08, 8'h00, 2, 0);
    i2c_start();
    send_byte(8'h35, 1'b0, "ack_rd_addr");
    rd_byte(bv);
    chk("rd_byte_hi", 32'(bv), 32'h01);
    put_bit(1'b0);
    rd_byte(bv);
    chk("rd_byte_lo", 32'(bv), 32'hA5);
    put_bit(1'b1);
    i2c_stop();
`else
    frame(8'h35, 8'h00, 8'h00, 1, 1);            // read NACKed when reads disabled
`endif
    check_regs();
    frame(WR_ADDR, 8'h0A, 8'h5A, 3, 1, 1'b1);    // 1-clk SCL glitch inside byte0
    check_regs();

    for (int n = 0; n < 25; n++) begin
      b0 = ($urandom_range(0, 9) < 7) ? WR_ADDR : {7'($urandom_range(0, 127)), 1'b0};
      ra = ($urandom_range(0, 9) < 8) ? 7'($urandom_range(0, NREG - 1))
                                      : 7'($urandom_range(0, 127));
      if (ra == 7'h0F && $urandom_range(0, 3) != 0) ra = 7'h01;
      b1  = {ra, 1'($urandom_range(0, 1))};
      b2  = 8'($urandom);
      nb  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 3;
      stp = ($urandom_range(0, 4) != 0) || (n == 24);
      frame(b0, b1, b2, nb, stp);
      if (stp) check_regs();
    end

    // Reset while the target is driving the address ACK.
    i2c_start();
    bv = WR_ADDR;
    for (int i = 7; i >= 0; i--) put_bit(bv[i]);
    clks(Q);
    m_sda = 1'b1;
    clks(HP / 2);
    chk("ack_driven", 32'(sda_t), 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_sda_t", 32'(sda_t), 1);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_nack", 32'(nackc), 0);
    for (int i = 0; i < NREG; i++) m_rf[i] = 9'h000;
    m_nack = 0;
    clks(3);
    rst_n = 1'b1;
    clks(HP / 2);
    m_scl = 1'b1;
    clks(HP);
    m_scl = 1'b0;
    send_byte(8'h0C, 1'b1, "ack_post_rst");
    send_byte(8'h12, 1'b1, "ack_post_rst2");
    i2c_stop();
    check_regs();

    clks(10);
    chk("sb_empty", 32'(sb_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
